// File: rtl/cunit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, datapath
// control values, FSM state codes and the decoded control bundle.
package cunit_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] BU_NONE   = 5'b00000;
  localparam logic [4:0] BU_JUMP   = 5'b10000;
  localparam logic [1:0] BU_BRANCH = 2'b01;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_PASS_B = 5'b01111;

  // State codes stay plain constants so older debug tooling can decode state_o
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  typedef struct packed {
    logic [2:0] immSrc;
    logic       aluASrc;
    logic       aluBSrc;
    logic [4:0] aluOp;
    logic [2:0] dmCtrl;
    logic [1:0] ruDataWrSrc;
    logic [4:0] buOp;
    logic       isLoad;
    logic       isStore;
    logic       isBranch;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cunit_decode.sv
// Combinational instruction decoder: maps OpCode/Funct fields onto the
// datapath control bundle and flags encodings the core does not implement.
module cunit_decode
  import cunit_pkg::*;
#(
  parameter logic ENABLE_MEXT = 1'b0
) (
  input  logic [6:0] opCode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o
);

  logic f7Base;
  logic mext;
  logic shiftOp;

  assign f7Base  = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
  assign mext    = ENABLE_MEXT && (funct7_i == 7'b0000001);
  assign shiftOp = (funct3_i == 3'b001) || (funct3_i == 3'b101);

  always_comb begin
    ctrl_o  = CTRL_IDLE;
    legal_o = 1'b0;
    case (opCode_i)
      OP_R: begin
        legal_o      = f7Base || mext;
        ctrl_o.aluOp = {mext, funct7_i[5], funct3_i};
      end
      OP_I: begin
        // Only SRAI/SRLI use Funct7[5]; for other I-ops those bits are immediate
        legal_o        = !shiftOp || f7Base;
        ctrl_o.aluBSrc = 1'b1;
        ctrl_o.aluOp   = {1'b0, (funct3_i == 3'b101) && funct7_i[5], funct3_i};
      end
      OP_L: begin
        legal_o            = 1'b1;
        ctrl_o.aluBSrc     = 1'b1;
        ctrl_o.dmCtrl      = funct3_i;
        ctrl_o.ruDataWrSrc = WB_MEM;
        ctrl_o.isLoad      = 1'b1;
      end
      OP_S: begin
        legal_o        = 1'b1;
        ctrl_o.immSrc  = IMM_S;
        ctrl_o.aluBSrc = 1'b1;
        ctrl_o.dmCtrl  = funct3_i;
        ctrl_o.isStore = 1'b1;
      end
      OP_B: begin
        legal_o         = 1'b1;
        ctrl_o.immSrc   = IMM_B;
        ctrl_o.aluASrc  = 1'b1;
        ctrl_o.aluBSrc  = 1'b1;
        ctrl_o.buOp     = {BU_BRANCH, funct3_i};
        ctrl_o.isBranch = 1'b1;
      end
      OP_JAL: begin
        legal_o            = 1'b1;
        ctrl_o.immSrc      = IMM_J;
        ctrl_o.aluASrc     = 1'b1;
        ctrl_o.aluBSrc     = 1'b1;
        ctrl_o.ruDataWrSrc = WB_PC4;
        ctrl_o.buOp        = BU_JUMP;
      end
      OP_JALR: begin
        legal_o            = 1'b1;
        ctrl_o.immSrc      = IMM_I;
        ctrl_o.aluBSrc     = 1'b1;
        ctrl_o.ruDataWrSrc = WB_PC4;
        ctrl_o.buOp        = BU_JUMP;
      end
      OP_LUI: begin
        legal_o        = 1'b1;
        ctrl_o.immSrc  = IMM_U;
        ctrl_o.aluBSrc = 1'b1;
        ctrl_o.aluOp   = ALU_PASS_B;
      end
      OP_AUIPC: begin
        legal_o        = 1'b1;
        ctrl_o.immSrc  = IMM_U;
        ctrl_o.aluASrc = 1'b1;
        ctrl_o.aluBSrc = 1'b1;
        ctrl_o.aluOp   = ALU_ADD;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_cunit.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, issues
// memory handshakes and write strobes, traps illegal encodings, counts retires.
module multicycle_cunit
  import cunit_pkg::*;
#(
  parameter logic MEM_HANDSHAKE = 1'b1,
  parameter logic ENABLE_MEXT   = 1'b0,
  parameter int   CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       OpCode,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             mem_ready,
  output logic             IMemReq,
  output logic             DMemReq,
  output logic             IRWr,
  output logic             PCWr,
  output logic [2:0]       ImmSrc,
  output logic             ALUASrc,
  output logic             ALUBSrc,
  output logic [4:0]       ALUOp,
  output logic             DMWr,
  output logic [2:0]       DMCtrl,
  output logic [1:0]       RUDatawrSrc,
  output logic             RuWr,
  output logic [4:0]       BUOp,
  output logic             Illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  ctrl_t            dec;
  ctrl_t            ctrlOut;
  logic             legal;
  logic             memDone;
  logic             ctrlActive;

  cunit_decode #(
    .ENABLE_MEXT(ENABLE_MEXT)
  ) u_decode (
    .opCode_i (OpCode),
    .funct3_i (Funct3),
    .funct7_i (Funct7),
    .ctrl_o   (dec),
    .legal_o  (legal)
  );

  assign memDone = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next state and strobes; reset masks every strobe so nothing commits in that cycle
  always_comb begin
    state_d = state_q;
    IMemReq = 1'b0;
    DMemReq = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RuWr    = 1'b0;
    DMWr    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (memDone) begin
          IRWr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (dec.isBranch) begin
          PCWr    = 1'b1;
          state_d = S_FETCH;
        end else if (dec.isLoad || dec.isStore) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        DMemReq = 1'b1;
        DMWr    = dec.isStore;
        if (memDone) begin
          if (dec.isStore) begin
            PCWr    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RuWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      state_d = S_FETCH;
      IMemReq = 1'b0;
      DMemReq = 1'b0;
      IRWr    = 1'b0;
      PCWr    = 1'b0;
      RuWr    = 1'b0;
      DMWr    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (PCWr) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign ctrlActive = !rst && (state_q == S_DECODE || state_q == S_EXEC ||
                               state_q == S_MEM || state_q == S_WB);
  assign ctrlOut    = ctrlActive ? dec : CTRL_IDLE;

  assign ImmSrc      = ctrlOut.immSrc;
  assign ALUASrc     = ctrlOut.aluASrc;
  assign ALUBSrc     = ctrlOut.aluBSrc;
  assign ALUOp       = ctrlOut.aluOp;
  assign DMCtrl      = ctrlOut.dmCtrl;
  assign RUDatawrSrc = ctrlOut.ruDataWrSrc;
  assign BUOp        = ctrlOut.buOp;
  assign Illegal     = !rst && (state_q == S_TRAP);
  assign instret     = instret_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_cunit.sv
// Directed bench for multicycle_cunit: runs hand-picked instructions through
// the FSM and compares per-instruction tallies with hand-computed values.
module tb_multicycle_cunit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] OpCode = 7'b0110011;
  logic [2:0] Funct3 = 3'b000;
  logic [6:0] Funct7 = 7'b0000000;
  logic       memReady = 1'b1;

  logic       IMemReq, DMemReq, IRWr, PCWr, ALUASrc, ALUBSrc, DMWr, RuWr, Illegal;
  logic [2:0] ImmSrc, DMCtrl, stateO;
  logic [4:0] ALUOp, BUOp;
  logic [1:0] RUDatawrSrc;
  logic [3:0] instret;

  logic        mIMemReq, mDMemReq, mIRWr, mPCWr, mALUASrc, mALUBSrc, mDMWr, mRuWr, mIllegal;
  logic [2:0]  mImmSrc, mDMCtrl, mStateO;
  logic [4:0]  mALUOp, mBUOp;
  logic [1:0]  mRUDatawrSrc;
  logic [31:0] mInstret;

  int checkCount = 0;
  int passCount  = 0;

  int          cycles, ruWrCnt, pcWrCnt, dmReqCnt, dmWrCnt, imReqCnt, irWrCnt;
  logic [31:0] trace, pcWrState, ruWrState;
  logic [31:0] exAluOp, exImm, exBu, exRud, exDmCtrl, exASrc, exBSrc, mExAluOp;

  always #5 clk = ~clk;

  multicycle_cunit #(.MEM_HANDSHAKE(1'b1), .ENABLE_MEXT(1'b0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .mem_ready(memReady), .IMemReq(IMemReq), .DMemReq(DMemReq), .IRWr(IRWr),
    .PCWr(PCWr), .ImmSrc(ImmSrc), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc),
    .ALUOp(ALUOp), .DMWr(DMWr), .DMCtrl(DMCtrl), .RUDatawrSrc(RUDatawrSrc),
    .RuWr(RuWr), .BUOp(BUOp), .Illegal(Illegal), .instret(instret), .state_o(stateO)
  );

  multicycle_cunit #(.MEM_HANDSHAKE(1'b1), .ENABLE_MEXT(1'b1), .CNT_W(32)) dutM (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .mem_ready(memReady), .IMemReq(mIMemReq), .DMemReq(mDMemReq), .IRWr(mIRWr),
    .PCWr(mPCWr), .ImmSrc(mImmSrc), .ALUASrc(mALUASrc), .ALUBSrc(mALUBSrc),
    .ALUOp(mALUOp), .DMWr(mDMWr), .DMCtrl(mDMCtrl), .RUDatawrSrc(mRUDatawrSrc),
    .RuWr(mRuWr), .BUOp(mBUOp), .Illegal(mIllegal), .instret(mInstret), .state_o(mStateO)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    rst = r; memReady = rdy; OpCode = op; Funct3 = f3; Funct7 = f7;
    #1;
  endtask

  // Runs one instruction from FETCH until its PCWr cycle (or TRAP), tallying strobes
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input int fetchWait, input int memWait);
    int  fLeft = fetchWait;
    int  mLeft = memWait;
    bit  done  = 0;
    logic rdy;
    cycles = 0; ruWrCnt = 0; pcWrCnt = 0; dmReqCnt = 0; dmWrCnt = 0;
    imReqCnt = 0; irWrCnt = 0; trace = '0; pcWrState = '1; ruWrState = '1;
    while (!done && cycles < 40) begin
      rdy = 1'b1;
      @(negedge clk);
      if (stateO == 3'd0 && fLeft > 0) begin rdy = 1'b0; fLeft--; end
      if (stateO == 3'd3 && mLeft > 0) begin rdy = 1'b0; mLeft--; end
      rst = 1'b0; memReady = rdy; OpCode = op; Funct3 = f3; Funct7 = f7;
      #1;
      cycles++;
      trace = (trace << 3) | 32'(stateO);
      if (RuWr)    begin ruWrCnt++; ruWrState = 32'(stateO); end
      if (DMemReq) dmReqCnt++;
      if (DMWr)    dmWrCnt++;
      if (IMemReq) imReqCnt++;
      if (IRWr)    irWrCnt++;
      if (stateO == 3'd2) begin
        exAluOp = 32'(ALUOp); exImm = 32'(ImmSrc); exBu = 32'(BUOp); exRud = 32'(RUDatawrSrc);
        exDmCtrl = 32'(DMCtrl); exASrc = 32'(ALUASrc); exBSrc = 32'(ALUBSrc);
      end
      if (mStateO == 3'd2) mExAluOp = 32'(mALUOp);
      if (PCWr) begin pcWrCnt++; pcWrState = 32'(stateO); done = 1; end
      if (stateO == 3'd5) done = 1;
    end
    checkOutput("instr completes within budget", 32'(done), 32'd1);
  endtask

  task automatic checkInstret(input logic [31:0] expected);
    @(posedge clk);
    #1;
    checkOutput("instret", 32'(instret), expected);
  endtask

  initial begin
    applyStimulus(1, 1, 7'b0110011, 3'b000, 7'b0000000);
    checkOutput("reset IMemReq", 32'(IMemReq), 32'd0);
    checkOutput("reset PCWr", 32'(PCWr), 32'd0);
    applyStimulus(1, 1, 7'b0110011, 3'b000, 7'b0000000);
    checkOutput("reset state", 32'(stateO), 32'd0);
    checkOutput("reset instret", 32'(instret), 32'd0);
    checkOutput("reset Illegal", 32'(Illegal), 32'd0);
    checkOutput("reset ALUOp idle", 32'(ALUOp), 32'd0);

    // add x3,x1,x2
    runInstr(7'b0110011, 3'b000, 7'b0000000, 0, 0);
    checkOutput("add cycles", 32'(cycles), 32'd4);
    checkOutput("add state trace", trace, 32'o124);
    checkOutput("add RuWr count", 32'(ruWrCnt), 32'd1);
    checkOutput("add RuWr state", ruWrState, 32'd4);
    checkOutput("add PCWr state", pcWrState, 32'd4);
    checkOutput("add ALUOp", exAluOp, 32'h00);
    checkInstret(32'd1);

    // lw with three wait cycles in MEM
    runInstr(7'b0000011, 3'b010, 7'b0000000, 0, 3);
    checkOutput("lw cycles", 32'(cycles), 32'd8);
    checkOutput("lw state trace", trace, 32'o1233334);
    checkOutput("lw DMemReq cycles", 32'(dmReqCnt), 32'd4);
    checkOutput("lw DMWr cycles", 32'(dmWrCnt), 32'd0);
    checkOutput("lw DMCtrl", exDmCtrl, 32'b010);
    checkOutput("lw RUDatawrSrc", exRud, 32'b01);
    checkOutput("lw RuWr count", 32'(ruWrCnt), 32'd1);
    checkInstret(32'd2);

    // beq
    runInstr(7'b1100011, 3'b000, 7'b0000000, 0, 0);
    checkOutput("beq cycles", 32'(cycles), 32'd3);
    checkOutput("beq BUOp", exBu, 32'b01000);
    checkOutput("beq ImmSrc", exImm, 32'b101);
    checkOutput("beq PCWr state", pcWrState, 32'd2);
    checkOutput("beq RuWr count", 32'(ruWrCnt), 32'd0);
    checkInstret(32'd3);

    // sw
    runInstr(7'b0100011, 3'b010, 7'b0000000, 0, 0);
    checkOutput("sw cycles", 32'(cycles), 32'd4);
    checkOutput("sw DMWr cycles", 32'(dmWrCnt), 32'd1);
    checkOutput("sw ImmSrc", exImm, 32'b001);
    checkOutput("sw PCWr state", pcWrState, 32'd3);
    checkOutput("sw RuWr count", 32'(ruWrCnt), 32'd0);
    checkInstret(32'd4);

    // jalr
    runInstr(7'b1100111, 3'b000, 7'b0000000, 0, 0);
    checkOutput("jalr cycles", 32'(cycles), 32'd4);
    checkOutput("jalr RUDatawrSrc", exRud, 32'b10);
    checkOutput("jalr RuWr count", 32'(ruWrCnt), 32'd1);
    checkOutput("jalr BUOp", exBu, 32'b10000);
    checkOutput("jalr ALUASrc/ALUBSrc", {exASrc[15:0], exBSrc[15:0]}, 32'h0000_0001);
    checkInstret(32'd5);

    // lui, srai, addi with imm bit 10 set, auipc with two fetch wait cycles
    runInstr(7'b0110111, 3'b000, 7'b0000000, 0, 0);
    checkOutput("lui ALUOp", exAluOp, 32'b01111);
    checkOutput("lui ImmSrc", exImm, 32'b010);
    checkInstret(32'd6);
    runInstr(7'b0010011, 3'b101, 7'b0100000, 0, 0);
    checkOutput("srai ALUOp", exAluOp, 32'b01101);
    checkInstret(32'd7);
    runInstr(7'b0010011, 3'b000, 7'b0100000, 0, 0);
    checkOutput("addi ALUOp", exAluOp, 32'b00000);
    checkOutput("addi ALUBSrc", exBSrc, 32'd1);
    checkInstret(32'd8);
    runInstr(7'b0010111, 3'b000, 7'b0000000, 2, 0);
    checkOutput("auipc cycles", 32'(cycles), 32'd6);
    checkOutput("auipc IMemReq cycles", 32'(imReqCnt), 32'd3);
    checkOutput("auipc IRWr count", 32'(irWrCnt), 32'd1);
    checkOutput("auipc ALUASrc", exASrc, 32'd1);
    checkOutput("auipc ImmSrc", exImm, 32'b010);
    checkInstret(32'd9);

    // div encoding: traps without M-extension, decodes with it
    runInstr(7'b0110011, 3'b100, 7'b0000001, 0, 0);
    checkOutput("mext trap trace", trace, 32'o15);
    checkOutput("mext ALUOp with ENABLE_MEXT", mExAluOp, 32'b10100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 7'b0110011, 3'b000, 7'b0000000);
      checkOutput("trap state held", 32'(stateO), 32'd5);
      checkOutput("trap Illegal held", 32'(Illegal), 32'd1);
      checkOutput("trap IMemReq", 32'(IMemReq), 32'd0);
    end
    checkOutput("trap instret frozen", 32'(instret), 32'd9);

    // reset while a store sits in MEM with mem_ready high
    applyStimulus(1, 1, 7'b0100011, 3'b010, 7'b0000000);
    applyStimulus(0, 1, 7'b0100011, 3'b010, 7'b0000000);
    checkOutput("post-reset Illegal", 32'(Illegal), 32'd0);
    checkOutput("post-reset instret", 32'(instret), 32'd0);
    applyStimulus(0, 1, 7'b0100011, 3'b010, 7'b0000000);
    applyStimulus(0, 1, 7'b0100011, 3'b010, 7'b0000000);
    applyStimulus(1, 1, 7'b0100011, 3'b010, 7'b0000000);
    checkOutput("rst-in-MEM state", 32'(stateO), 32'd3);
    checkOutput("rst-in-MEM DMWr", 32'(DMWr), 32'd0);
    checkOutput("rst-in-MEM PCWr", 32'(PCWr), 32'd0);
    applyStimulus(0, 0, 7'b0100011, 3'b010, 7'b0000000);
    checkOutput("after rst-in-MEM state", 32'(stateO), 32'd0);
    checkOutput("after rst-in-MEM instret", 32'(instret), 32'd0);
    checkOutput("after rst-in-MEM Illegal", 32'(Illegal), 32'd0);

    // 17 retires: 4-bit counter wraps to 1, 32-bit counter reaches 17
    for (int i = 0; i < 17; i++) runInstr(7'b0010011, 3'b000, 7'b0000000, 0, 0);
    checkInstret(32'd1);
    checkOutput("instret 32-bit", mInstret, 32'd17);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
